// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
// Shared definitions for the program-counter stage: default address width,
// reset PC, the next-PC mux select codes and a small sizing helper.
package pc_sequencer_pkg;

   localparam int PC_ADDR_W = 19;
   localparam logic [PC_ADDR_W-1:0] PC_RESET_PC = '0;

   // Select codes for the external 4:1 next-PC mux (i1..i4).
   typedef enum logic [1:0] {
      SEL_SEQ = 2'b00,
      SEL_BR  = 2'b01,
      SEL_JMP = 2'b10,
      SEL_RET = 2'b11
   } sel_e;

   // Counter width able to hold 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// pc_sequencer_ras_stack
// Return-address LIFO with circular storage. A push into a full stack
// overwrites the oldest entry and leaves the count saturated at DEPTH.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   push, pop   stack operations (push wins if both are asserted)
//   din         value to push
//   top         most recent entry, 0 when empty
//   count       number of valid entries (0..DEPTH)
//   full, empty status
module pc_sequencer_ras_stack
   import pc_sequencer_pkg::*;
#(
   parameter int W     = PC_ADDR_W,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             top,
   output logic [cnt_w(DEPTH)-1:0]  count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = cnt_w(DEPTH);

   logic [DEPTH-1:0][W-1:0] mem;
   // ptr is the next write slot; DEPTH is a power of two so it wraps for free,
   // which is exactly what makes a full push land on the oldest entry.
   logic [PTR_W-1:0]        ptr;
   logic [PTR_W-1:0]        top_idx;

   assign top_idx = ptr - PTR_W'(1);
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign top     = empty ? '0 : mem[top_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem   <= '0;
         ptr   <= '0;
         count <= '0;
      end else if (push) begin
         mem[ptr] <= din;
         ptr      <= ptr + PTR_W'(1);
         if (!full)
            count <= count + CNT_W'(1);
      end else if (pop && !empty) begin
         ptr   <= top_idx;
         count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program-counter stage wrapped around the external 4:1 next-PC mux. Builds
// the four candidates and the select, then registers the mux output as the
// new PC every un-stalled cycle. Holds a return-address stack for call/ret.
// Ports:
//   clk, rst_n        clock / async active-low reset
//   stall             hold PC, RAS and flags this cycle
//   branch_taken      conditional branch taken, target pc+branch_offset
//   branch_offset     signed PC-relative offset
//   jump, call, ret   control flow requests (priority ret > call > jump > branch)
//   jump_target       absolute target for jump/call
//   mux_q             next-PC mux output
//   mux_s             mux select (00 seq, 01 br, 10 jmp/call, 11 ret)
//   cand_seq/br/jmp/ret  mux inputs i1..i4
//   pc                current PC
//   ras_overflow      one-cycle pulse after a push into a full RAS
//   ras_underflow     one-cycle pulse after a ret with an empty RAS
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int                ADDR_W    = PC_ADDR_W,
   parameter int                RAS_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_offset,
   input  logic              jump,
   input  logic              call,
   input  logic              ret,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic [ADDR_W-1:0] mux_q,
   output logic [1:0]        mux_s,
   output logic [ADDR_W-1:0] cand_seq,
   output logic [ADDR_W-1:0] cand_br,
   output logic [ADDR_W-1:0] cand_jmp,
   output logic [ADDR_W-1:0] cand_ret,
   output logic [ADDR_W-1:0] pc,
   output logic              ras_overflow,
   output logic              ras_underflow
);

   sel_e sel;
   logic do_push, do_pop;
   logic ras_full, ras_empty;
   logic [cnt_w(RAS_DEPTH)-1:0] ras_count;

   // Modulo-2^ADDR_W arithmetic falls out of the fixed-width adders.
   assign cand_seq = pc + ADDR_W'(1);
   assign cand_br  = pc + branch_offset;
   assign cand_jmp = jump_target;

   // A ret always shadows a simultaneous call, even when it has nothing to
   // pop and just falls through.
   always_comb begin
      sel = SEL_SEQ;
      if (ret)
         sel = ras_empty ? SEL_SEQ : SEL_RET;
      else if (call || jump)
         sel = SEL_JMP;
      else if (branch_taken)
         sel = SEL_BR;
   end

   assign mux_s   = sel;
   assign do_push = !stall && call && !ret;
   assign do_pop  = !stall && ret && !ras_empty;

   pc_sequencer_ras_stack #(
      .W     (ADDR_W),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (do_push),
      .pop   (do_pop),
      .din   (cand_seq),
      .top   (cand_ret),
      .count (ras_count),
      .full  (ras_full),
      .empty (ras_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc            <= RESET_PC;
         ras_overflow  <= 1'b0;
         ras_underflow <= 1'b0;
      end else begin
         ras_overflow  <= do_push && ras_full;
         ras_underflow <= !stall && ret && ras_empty;
         if (!stall)
            pc <= mux_q;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

   localparam int W = 19;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         stall, branch_taken, jump, call, ret;
   logic [W-1:0] branch_offset, jump_target, mux_q;
   logic [1:0]   mux_s;
   logic [W-1:0] cand_seq, cand_br, cand_jmp, cand_ret, pc;
   logic         ras_overflow, ras_underflow;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pc_sequencer #(.ADDR_W(W), .RAS_DEPTH(4), .RESET_PC('0)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .jump          (jump),
      .call          (call),
      .ret           (ret),
      .jump_target   (jump_target),
      .mux_q         (mux_q),
      .mux_s         (mux_s),
      .cand_seq      (cand_seq),
      .cand_br       (cand_br),
      .cand_jmp      (cand_jmp),
      .cand_ret      (cand_ret),
      .pc            (pc),
      .ras_overflow  (ras_overflow),
      .ras_underflow (ras_underflow)
   );

   // Next-PC mux closing the loop.
   always_comb begin
      case (mux_s)
         2'b00:   mux_q = cand_seq;
         2'b01:   mux_q = cand_br;
         2'b10:   mux_q = cand_jmp;
         default: mux_q = cand_ret;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      branch_taken = 0; jump = 0; call = 0; ret = 0; stall = 0;
      branch_offset = '0; jump_target = '0;
   endtask

   // Jump to an absolute PC in one cycle.
   task automatic go(input logic [W-1:0] t);
      idle(); jump = 1; jump_target = t;
      tick();
      idle();
   endtask

   initial begin
      rst_n = 0;
      idle();
      #12;
      // 1. reset state then sequential flow
      chk("rst_pc", 32'(pc), 32'h0);
      chk("rst_cnt", 32'(dut.u_ras.count), 32'h0);
      chk("rst_ovf", 32'(ras_overflow), 32'h0);
      chk("rst_unf", 32'(ras_underflow), 32'h0);
      #5 rst_n = 1;
      #1;
      for (int i = 1; i <= 3; i++) begin
         chk("seq_sel", 32'(mux_s), 32'h0);
         tick();
         chk($sformatf("seq_pc%0d", i), 32'(pc), 32'(i));
      end

      // backward branch wrapping below zero
      go(19'h0);
      branch_taken = 1; branch_offset = 19'h7FFFF; #1;
      chk("br_wrap_neg", 32'(cand_br), 32'h7FFFF);
      idle();

      // 2. branch back by 4
      go(19'h00010);
      branch_taken = 1; branch_offset = 19'h7FFFC; #1;
      chk("br_sel", 32'(mux_s), 32'h1);
      tick();
      chk("br_pc", 32'(pc), 32'h0000C);
      idle();

      // 3. call then ret
      go(19'h00020);
      call = 1; jump_target = 19'h01000; #1;
      chk("call_sel", 32'(mux_s), 32'h2);
      tick();
      chk("call_pc", 32'(pc), 32'h01000);
      chk("call_cnt", 32'(dut.u_ras.count), 32'h1);
      idle(); ret = 1; #1;
      chk("ret_sel", 32'(mux_s), 32'h3);
      tick();
      chk("ret_pc", 32'(pc), 32'h00021);
      chk("ret_cnt", 32'(dut.u_ras.count), 32'h0);
      idle();

      // 4. five nested calls from 0x21: pushes 22,101,201,301,401 (22 lost)
      for (int i = 1; i <= 5; i++) begin
         call = 1; jump_target = 19'(i * 32'h100);
         tick();
         chk($sformatf("ncall_pc%0d", i), 32'(pc), 32'(i * 32'h100));
         chk($sformatf("ncall_ovf%0d", i), 32'(ras_overflow), (i == 5) ? 32'h1 : 32'h0);
      end
      chk("ncall_cnt", 32'(dut.u_ras.count), 32'h4);
      idle();
      for (int i = 4; i >= 1; i--) begin
         ret = 1; #1;
         chk($sformatf("nret_sel%0d", i), 32'(mux_s), 32'h3);
         tick();
         chk($sformatf("nret_pc%0d", i), 32'(pc), 32'(i * 32'h100 + 1));
         chk($sformatf("nret_ovf%0d", i), 32'(ras_overflow), 32'h0);
      end
      ret = 1; #1;
      chk("unf_sel", 32'(mux_s), 32'h0);
      chk("unf_top", 32'(cand_ret), 32'h0);
      tick();
      chk("unf_pc", 32'(pc), 32'h00102);
      chk("unf_flag", 32'(ras_underflow), 32'h1);
      idle();
      tick();
      chk("unf_clr", 32'(ras_underflow), 32'h0);

      // 5. PC wrap and call+ret together
      go(19'h7FFFF);
      #1 chk("wrap_seq", 32'(cand_seq), 32'h0);
      tick();
      chk("wrap_pc", 32'(pc), 32'h0);
      go(19'h002FF);
      call = 1; jump_target = 19'h00050;
      tick();
      chk("cr_cnt1", 32'(dut.u_ras.count), 32'h1);
      call = 1; ret = 1; jump_target = 19'h00900; #1;
      chk("cr_sel", 32'(mux_s), 32'h3);
      tick();
      chk("cr_pc", 32'(pc), 32'h00300);
      chk("cr_cnt0", 32'(dut.u_ras.count), 32'h0);
      idle();

      // 6. stalled call, then release, then async reset mid-cycle
      stall = 1; call = 1; jump_target = 19'h00700;
      for (int i = 0; i < 3; i++) begin
         #1 chk("stl_sel", 32'(mux_s), 32'h2);
         tick();
         chk("stl_pc", 32'(pc), 32'h00300);
         chk("stl_cnt", 32'(dut.u_ras.count), 32'h0);
      end
      stall = 0;
      tick();
      chk("rel_pc", 32'(pc), 32'h00700);
      chk("rel_cnt", 32'(dut.u_ras.count), 32'h1);
      chk("rel_top", 32'(cand_ret), 32'h00301);
      call = 1; jump_target = 19'h00800;
      tick();
      chk("pre_rst_cnt", 32'(dut.u_ras.count), 32'h2);
      #2 rst_n = 0;
      #1;
      chk("mid_rst_pc", 32'(pc), 32'h0);
      chk("mid_rst_cnt", 32'(dut.u_ras.count), 32'h0);
      idle();
      tick();
      rst_n = 1;
      tick();
      chk("post_rst_pc", 32'(pc), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
